// File: rtl/filtered_synchronizer.sv
// Multi-channel CDC synchronizer with optional per-channel stability filter
// and registered-source edge-detect pulses.
module filtered_synchronizer #(
  parameter int              WIDTH         = 1,
  parameter int              STAGES        = 2,
  parameter int              FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rising_edge,
  output logic [WIDTH-1:0] falling_edge
);

  if (WIDTH < 1) begin : g_bad_width
    $error("filtered_synchronizer: WIDTH must be >= 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("filtered_synchronizer: STAGES must be >= 1");
  end
  if (FILTER_CYCLES < 0) begin : g_bad_filter
    $error("filtered_synchronizer: FILTER_CYCLES must be >= 0");
  end

  // Guarded depth keeps the array legal while the error above reports.
  localparam int unsigned NST = (STAGES < 1) ? 1 : STAGES;

  logic [WIDTH-1:0] r_chain [NST];
  logic [WIDTH-1:0] r_data_out_prev;
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_data_out;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < int'(NST); s++) r_chain[s] <= RESET_VALUE;
    end else begin
      r_chain[0] <= data_in;
      for (int s = 1; s < int'(NST); s++) r_chain[s] <= r_chain[s-1];
    end
  end

  assign w_sync = r_chain[NST-1];

  if (FILTER_CYCLES <= 0) begin : g_nofilt
    assign w_data_out = w_sync;
  end else begin : g_filt
    localparam int unsigned     CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0] r_data_out;

    // Output follows sync only after FILTER_CYCLES consecutive mismatching edges.
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        r_data_out <= RESET_VALUE;
        for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
        for (int i = 0; i < WIDTH; i++) begin
          if (w_sync[i] == r_data_out[i]) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] < CNT_LAST) begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end else begin
            r_data_out[i] <= w_sync[i];
            r_cnt[i]      <= '0;
          end
        end
      end
    end

    assign w_data_out = r_data_out;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_data_out_prev <= RESET_VALUE;
    else         r_data_out_prev <= w_data_out;
  end

  assign data_out     = w_data_out;
  assign rising_edge  =  w_data_out & ~r_data_out_prev;
  assign falling_edge = ~w_data_out &  r_data_out_prev;

endmodule

// File: tb/tb_filtered_synchronizer.sv
// Directed bench: table of per-edge vectors on a 4-channel filtered instance,
// plus reset, mid-filter reset and STAGES/FILTER_CYCLES latency sweep sequences.
module tb_filtered_synchronizer;

  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] data_in;
  logic [3:0] out_a, rise_a, fall_a;
  logic [3:0] out_b, rise_b, fall_b;
  logic [0:0] sw_in;
  logic [9:0] sw_out, sw_rise, sw_fall;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  filtered_synchronizer #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VALUE(4'b0000)) dut_a (
    .clock(clock), .resetn(resetn), .data_in(data_in),
    .data_out(out_a), .rising_edge(rise_a), .falling_edge(fall_a));

  filtered_synchronizer #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VALUE(4'b1010)) dut_b (
    .clock(clock), .resetn(resetn), .data_in(data_in),
    .data_out(out_b), .rising_edge(rise_b), .falling_edge(fall_b));

  for (genvar s = 1; s <= 5; s++) begin : g_s
    for (genvar f = 0; f <= 1; f++) begin : g_f
      logic [0:0] o, r, fl;
      filtered_synchronizer #(.WIDTH(1), .STAGES(s), .FILTER_CYCLES(f)) u_sw (
        .clock(clock), .resetn(resetn), .data_in(sw_in),
        .data_out(o), .rising_edge(r), .falling_edge(fl));
      assign sw_out [(s-1)*2+f] = o[0];
      assign sw_rise[(s-1)*2+f] = r[0];
      assign sw_fall[(s-1)*2+f] = fl[0];
    end
  end

  typedef struct {
    logic [3:0] din;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int lat [10];
  int rlat[10];
  int nfall;

  initial begin
    resetn  = 1'b0;
    data_in = 4'b1111;
    sw_in   = 1'b0;

    // Edge-by-edge vectors following reset release with all channels at 1111.
    vecs.push_back('{4'b0000, 4'b1111, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b1111, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b1111, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b1111, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b1111});
    vecs.push_back('{4'b0001, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0001, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0100, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0100, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0100, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0100, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0100, 4'b0100, 4'b0100, 4'b0000});
    vecs.push_back('{4'b0100, 4'b0100, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0100, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0100, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0100, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0100, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0000, 4'b0000, 4'b0000, 4'b0100});
    vecs.push_back('{4'b0101, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0101, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0101, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0101, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0101, 4'b0101, 4'b0101, 4'b0000});
    vecs.push_back('{4'b0101, 4'b0101, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0111, 4'b0101, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0111, 4'b0101, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0111, 4'b0101, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0101, 4'b0101, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0101, 4'b0111, 4'b0010, 4'b0000});
    vecs.push_back('{4'b0101, 4'b0111, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0101, 4'b0111, 4'b0000, 4'b0000});
    vecs.push_back('{4'b0101, 4'b0101, 4'b0000, 4'b0010});
    vecs.push_back('{4'b0101, 4'b0101, 4'b0000, 4'b0000});

    // Reset held with inputs high: outputs stay at reset value, no pulses.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", {20'd0, out_a, rise_a, fall_a}, 32'd0);
    end
    @(negedge clock);
    resetn = 1'b1;
    #1;
    check("reset_release_nopulse", {24'd0, rise_a, fall_a}, 32'd0);
    for (int e = 0; e <= 5; e++) begin
      tick();
      check($sformatf("post_reset_e%0d", e), {20'd0, out_a, rise_a, fall_a},
            {20'd0, (e >= 4) ? 4'b1111 : 4'b0000, (e == 4) ? 4'b1111 : 4'b0000, 4'b0000});
    end

    foreach (vecs[k]) begin
      @(negedge clock);
      data_in = vecs[k].din;
      tick();
      check($sformatf("vec%0d", k), {20'd0, out_a, rise_a, fall_a},
            {20'd0, vecs[k].out, vecs[k].rise, vecs[k].fall});
    end

    // Reset with a channel's counter at 2, then verify a full recount.
    @(negedge clock);
    resetn = 1'b0;
    #1;
    check("midrst_a_reset", {20'd0, out_a, rise_a, fall_a}, 32'd0);
    check("midrst_b_reset", {20'd0, out_b, rise_b, fall_b}, {20'd0, 4'b1010, 8'd0});
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clock);
      resetn = 1'b1;
      #1;
      check($sformatf("midrst_release_p%0d", pass), {16'd0, rise_a, fall_a, rise_b, fall_b}, 32'd0);
      for (int e = 0; e <= 3; e++) begin
        tick();
        check($sformatf("midrst_a_p%0d_e%0d", pass, e), {20'd0, out_a, rise_a, fall_a}, 32'd0);
        check($sformatf("midrst_b_p%0d_e%0d", pass, e), {20'd0, out_b, rise_b, fall_b},
              {20'd0, 4'b1010, 8'd0});
      end
      if (pass == 0) begin
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("midrst_abort_a", {20'd0, out_a, rise_a, fall_a}, 32'd0);
        check("midrst_abort_b", {20'd0, out_b, rise_b, fall_b}, {20'd0, 4'b1010, 8'd0});
        tick();
      end
    end
    tick();
    check("midrst_a_update", {20'd0, out_a, rise_a, fall_a}, {20'd0, 4'b0101, 4'b0101, 4'b0000});
    check("midrst_b_update", {20'd0, out_b, rise_b, fall_b}, {20'd0, 4'b0101, 4'b0101, 4'b1010});
    tick();
    check("midrst_a_after", {20'd0, out_a, rise_a, fall_a}, {20'd0, 4'b0101, 8'd0});

    // Latency sweep: capture edge is cycle 0.
    repeat (8) tick();
    for (int j = 0; j < 10; j++) begin
      lat[j]  = -1;
      rlat[j] = -1;
    end
    nfall = 0;
    check("sweep_idle", {22'd0, sw_out}, 32'd0);
    @(negedge clock);
    sw_in = 1'b1;
    for (int cyc = 0; cyc <= 8; cyc++) begin
      tick();
      for (int j = 0; j < 10; j++) begin
        if (sw_out[j]  && lat[j]  < 0) lat[j]  = cyc;
        if (sw_rise[j] && rlat[j] < 0) rlat[j] = cyc;
        if (sw_fall[j]) nfall++;
      end
    end
    for (int s = 1; s <= 5; s++) begin
      for (int f = 0; f <= 1; f++) begin
        check($sformatf("sweep_lat_s%0d_f%0d", s, f), lat[(s-1)*2+f], s - 1 + f);
        check($sformatf("sweep_rise_s%0d_f%0d", s, f), rlat[(s-1)*2+f], s - 1 + f);
      end
    end
    check("sweep_no_fall", nfall, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
